// File: rtl/thiele_pkg.sv
// Shared definitions for the Thiele partition core: opcodes, error codes,
// FSM state encoding and the instruction field layout.
package thiele_pkg;

  localparam logic [7:0] OP_PNEW    = 8'h01;
  localparam logic [7:0] OP_PSPLIT  = 8'h02;
  localparam logic [7:0] OP_PMERGE  = 8'h03;
  localparam logic [7:0] OP_LASSERT = 8'h04;
  localparam logic [7:0] OP_EMIT    = 8'h05;
  localparam logic [7:0] OP_PWRITE  = 8'h06;
  localparam logic [7:0] OP_HALT    = 8'hFF;

  localparam logic [31:0] ERR_UNKNOWN = 32'd1;
  localparam logic [31:0] ERR_FULL    = 32'd2;
  localparam logic [31:0] ERR_INVALID = 32'd3;
  localparam logic [31:0] ERR_MU_SAT  = 32'd4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXEC,
    ST_SCAN,
    ST_COMMIT,
    ST_HALTED
  } state_t;

  typedef struct packed {
    logic [7:0] opcode;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] cost;
  } instr_t;

endpackage

// File: rtl/thiele_free_alloc.sv
// Lowest-free-first module ID finder: combinational priority encoder over
// the module-table valid bits.
module thiele_free_alloc #(
  parameter int NUM_MODULES = 8,
  localparam int ID_W = $clog2(NUM_MODULES)
) (
  input  logic [NUM_MODULES-1:0] i_valid,
  output logic [ID_W-1:0]        o_id,
  output logic                   o_found
);

  // Scanning downwards lets the lowest free entry win the final assignment.
  always_comb begin
    o_id    = '0;
    o_found = 1'b0;
    for (int i = NUM_MODULES - 1; i >= 0; i--) begin
      if (!i_valid[i]) begin
        o_id    = ID_W'(i);
        o_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/thiele_partition_core.sv
// Thiele partition core: executes the partition instruction set over a module
// table and region memory, accumulating mu-cost. Define MU_SATURATE_EN for a saturating mu.
module thiele_partition_core
  import thiele_pkg::*;
#(
  parameter int NUM_MODULES = 8,
  parameter int REGION_SIZE = 16,
  parameter int MU_W        = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_instr_valid,
  output logic            o_instr_ready,
  input  logic [31:0]     i_instr_data,
  output logic [31:0]     o_pc,
  output logic [MU_W-1:0] o_mu_cost,
  output logic [31:0]     o_status,
  output logic [31:0]     o_error_code,
  output logic            o_busy,
  output logic            o_halted
);

  localparam int ID_W   = $clog2(NUM_MODULES);
  localparam int IDX_W  = $clog2(REGION_SIZE);
  localparam int CNT_W  = IDX_W + 1;
  localparam int ADDR_W = ID_W + IDX_W;
  localparam int DEPTH  = NUM_MODULES * REGION_SIZE;

  state_t                 r_state, w_nextState;
  instr_t                 r_instr;
  logic [NUM_MODULES-1:0] r_valid;
  logic [31:0]            r_pc, r_status, r_err;
  logic [MU_W-1:0]        r_mu;
  logic [IDX_W-1:0]       r_scanIdx;
  logic [CNT_W-1:0]       r_count;
  logic [31:0]            r_region [DEPTH];

  logic [ID_W-1:0]   w_allocId, w_aId, w_bId;
  logic              w_allocFound, w_aValid, w_bValid, w_scanBit;
  logic              w_retire, w_success, w_setErr, w_allocEn, w_freeEn, w_we;
  logic [31:0]       w_errCode, w_newStatus, w_wData;
  logic [ADDR_W-1:0] w_wAddr;
  logic [9:0]        w_addend;
  logic [MU_W-1:0]   w_muNext;
  logic              w_sat;

  thiele_free_alloc #(.NUM_MODULES(NUM_MODULES)) u_alloc (
    .i_valid (r_valid),
    .o_id    (w_allocId),
    .o_found (w_allocFound)
  );

  assign w_aId     = r_instr.a[ID_W-1:0];
  assign w_bId     = r_instr.b[ID_W-1:0];
  assign w_aValid  = (r_instr.a < 8'(NUM_MODULES)) && r_valid[w_aId];
  assign w_bValid  = (r_instr.b < 8'(NUM_MODULES)) && r_valid[w_bId];
  assign w_scanBit = r_region[{w_aId, r_scanIdx}][0];

  // Next-state and per-instruction effects; registers below apply them.
  always_comb begin
    w_nextState = r_state;
    w_retire    = 1'b0;
    w_success   = 1'b0;
    w_setErr    = 1'b0;
    w_errCode   = '0;
    w_newStatus = '0;
    w_addend    = 10'(r_instr.cost);
    w_allocEn   = 1'b0;
    w_freeEn    = 1'b0;
    w_we        = 1'b0;
    w_wAddr     = '0;
    w_wData     = '0;
    case (r_state)
      ST_IDLE: if (i_instr_valid) w_nextState = ST_EXEC;
      ST_EXEC: begin
        w_nextState = ST_IDLE;
        w_retire    = 1'b1;
        case (r_instr.opcode)
          OP_PNEW: begin
            if (w_allocFound) begin
              w_success   = 1'b1;
              w_allocEn   = 1'b1;
              w_we        = 1'b1;
              w_wAddr     = {w_allocId, IDX_W'(0)};
              w_wData     = {24'h0, r_instr.a};
              w_newStatus = {16'h0, 8'(w_allocId), 8'h01};
            end else begin
              w_setErr  = 1'b1;
              w_errCode = ERR_FULL;
            end
          end
          OP_PSPLIT: begin
            if (w_aValid && w_allocFound) begin
              w_nextState = ST_SCAN;
              w_retire    = 1'b0;
            end else begin
              w_setErr  = 1'b1;
              w_errCode = ERR_INVALID;
            end
          end
          OP_PMERGE: begin
            if (w_aValid && w_bValid && (r_instr.a != r_instr.b) && (r_instr.b != 8'h0)) begin
              w_success   = 1'b1;
              w_freeEn    = 1'b1;
              w_newStatus = 32'h03;
            end else begin
              w_setErr  = 1'b1;
              w_errCode = ERR_INVALID;
            end
          end
          OP_LASSERT: begin
            w_success   = 1'b1;
            w_newStatus = 32'h04;
          end
          OP_EMIT: begin
            w_success   = 1'b1;
            w_newStatus = {16'h0, r_instr.a, r_instr.b};
          end
          OP_PWRITE: begin
            if (w_aValid) begin
              w_success   = 1'b1;
              w_we        = 1'b1;
              w_wAddr     = {w_aId, r_instr.b[IDX_W-1:0]};
              w_wData     = {24'h0, r_instr.cost};
              w_addend    = 10'd1;
              w_newStatus = 32'h06;
            end else begin
              w_setErr  = 1'b1;
              w_errCode = ERR_INVALID;
            end
          end
          OP_HALT: begin
            w_success   = 1'b1;
            w_newStatus = 32'hFF;
            w_nextState = ST_HALTED;
          end
          default: begin
            w_setErr  = 1'b1;
            w_errCode = ERR_UNKNOWN;
          end
        endcase
      end
      ST_SCAN: if (r_scanIdx == IDX_W'(REGION_SIZE - 1)) w_nextState = ST_COMMIT;
      ST_COMMIT: begin
        w_nextState = ST_IDLE;
        w_retire    = 1'b1;
        w_success   = 1'b1;
        w_allocEn   = 1'b1;
        w_we        = 1'b1;
        w_wAddr     = {w_allocId, IDX_W'(0)};
        w_wData     = 32'(r_count);
        w_addend    = 10'(r_instr.cost) + 10'(r_count);
        w_newStatus = {16'(r_count), 8'(w_allocId), 8'h02};
      end
      ST_HALTED: w_nextState = ST_HALTED;
      default:   w_nextState = ST_IDLE;
    endcase
  end

`ifdef MU_SATURATE_EN
  logic [MU_W+9:0] w_sum;
  always_comb begin
    w_sum    = (MU_W+10)'(r_mu) + (MU_W+10)'(w_addend);
    w_sat    = |w_sum[MU_W+9:MU_W];
    w_muNext = w_sat ? '1 : w_sum[MU_W-1:0];
  end
`else
  // Casting the addend to MU_W bits keeps the sum correct modulo 2^MU_W.
  always_comb begin
    w_sat    = 1'b0;
    w_muNext = r_mu + MU_W'(w_addend);
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_instr   <= '0;
      r_valid   <= NUM_MODULES'(1);
      r_pc      <= '0;
      r_mu      <= '0;
      r_status  <= '0;
      r_err     <= '0;
      r_scanIdx <= '0;
      r_count   <= '0;
    end else begin
      r_state <= w_nextState;
      if (r_state == ST_IDLE && i_instr_valid) r_instr <= instr_t'(i_instr_data);
      if (r_state == ST_EXEC) begin
        r_scanIdx <= '0;
        r_count   <= '0;
      end
      if (r_state == ST_SCAN) begin
        r_scanIdx <= r_scanIdx + IDX_W'(1);
        if (w_scanBit == r_instr.b[0]) r_count <= r_count + CNT_W'(1);
      end
      if (w_retire) r_pc <= r_pc + 32'd4;
      if (w_setErr) r_err <= w_errCode;
      if (w_success) begin
        r_mu     <= w_muNext;
        r_status <= w_newStatus;
        if (w_sat) r_err <= ERR_MU_SAT;
      end
      if (w_allocEn) r_valid[w_allocId] <= 1'b1;
      if (w_freeEn) r_valid[w_bId] <= 1'b0;
    end
  end

  // Region memory is deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_we) r_region[w_wAddr] <= w_wData;
  end

  assign o_instr_ready = (r_state == ST_IDLE);
  assign o_busy        = (r_state == ST_SCAN) || (r_state == ST_COMMIT);
  assign o_halted      = (r_state == ST_HALTED);
  assign o_pc          = r_pc;
  assign o_mu_cost     = r_mu;
  assign o_status      = r_status;
  assign o_error_code  = r_err;

endmodule

// File: tb/tb_thiele_partition_core.sv
// Self-checking bench for thiele_partition_core: directed and randomized
// instructions compared against a behavioural module-table/region model.
module tb_thiele_partition_core;

  localparam int NM = 4;
  localparam int RS = 8;
  localparam int MW = 8;
  localparam longint MU_MAX = (64'd1 << MW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_instr_valid = 1'b0;
  logic [31:0]   i_instr_data = '0;
  logic          o_instr_ready, o_busy, o_halted;
  logic [31:0]   o_pc, o_status, o_error_code;
  logic [MW-1:0] o_mu_cost;

  int total = 0;
  int passed = 0;
  int failed = 0;

  bit          mVal [NM];
  bit          mWr  [NM][RS];
  logic [31:0] mReg [NM][RS];
  logic [31:0] mPc, mStatus, mErr;
  longint      mMu;
  bit          mHalted;

  thiele_partition_core #(.NUM_MODULES(NM), .REGION_SIZE(RS), .MU_W(MW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_instr_valid (i_instr_valid),
    .o_instr_ready (o_instr_ready),
    .i_instr_data  (i_instr_data),
    .o_pc          (o_pc),
    .o_mu_cost     (o_mu_cost),
    .o_status      (o_status),
    .o_error_code  (o_error_code),
    .o_busy        (o_busy),
    .o_halted      (o_halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit isValid(input logic [7:0] id);
    return (int'(id) < NM) && mVal[int'(id)];
  endfunction

  function automatic int lowestFree();
    for (int i = 1; i < NM; i++) if (!mVal[i]) return i;
    return -1;
  endfunction

  function automatic bit allWritten(input logic [7:0] id);
    if (int'(id) >= NM) return 1'b1;
    for (int i = 0; i < RS; i++) if (!mWr[int'(id)][i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic muAdd(input int v);
    longint s;
    s = mMu + longint'(v);
`ifdef MU_SATURATE_EN
    if (s > MU_MAX) begin
      mMu  = MU_MAX;
      mErr = 32'd4;
    end else mMu = s;
`else
    mMu = s % (MU_MAX + 1);
`endif
  endtask

  task automatic modelReset();
    for (int i = 0; i < NM; i++) mVal[i] = (i == 0);
    mPc = 0; mMu = 0; mStatus = 0; mErr = 0; mHalted = 0;
  endtask

  // Architectural effect of one instruction; expLat<0 means ready never returns.
  task automatic modelExec(input logic [31:0] ins, output int expLat, output int expBusy);
    logic [7:0] op, a, b, cost;
    int id, cnt;
    {op, a, b, cost} = ins;
    expLat = 1; expBusy = 0;
    mPc += 4;
    id = lowestFree();
    case (op)
      8'h01: if (id < 0) mErr = 2;
             else begin
               mVal[id] = 1; mReg[id][0] = {24'h0, a}; mWr[id][0] = 1;
               muAdd(int'(cost)); mStatus = {16'h0, 8'(id), 8'h01};
             end
      8'h02: if (!isValid(a) || id < 0) mErr = 3;
             else begin
               cnt = 0;
               for (int i = 0; i < RS; i++) if (mReg[int'(a)][i][0] == b[0]) cnt++;
               mVal[id] = 1; mReg[id][0] = 32'(cnt); mWr[id][0] = 1;
               muAdd(int'(cost) + cnt);
               mStatus = {16'(cnt), 8'(id), 8'h02};
               expLat = RS + 2; expBusy = RS + 1;
             end
      8'h03: if (isValid(a) && isValid(b) && a != b && b != 0) begin
               mVal[int'(b)] = 0; muAdd(int'(cost)); mStatus = 32'h03;
             end else mErr = 3;
      8'h04: begin muAdd(int'(cost)); mStatus = 32'h04; end
      8'h05: begin muAdd(int'(cost)); mStatus = {16'h0, a, b}; end
      8'h06: if (isValid(a)) begin
               mReg[int'(a)][int'(b) % RS] = {24'h0, cost}; mWr[int'(a)][int'(b) % RS] = 1;
               muAdd(1); mStatus = 32'h06;
             end else mErr = 3;
      8'hFF: begin muAdd(int'(cost)); mStatus = 32'hFF; mHalted = 1; expLat = -1; end
      default: mErr = 1;
    endcase
  endtask

  task automatic applyStimulus(input logic [31:0] ins, input int maxWait,
                               output int cycles, output int busyCnt);
    int guard = 0;
    while (!o_instr_ready && guard < 50) begin @(negedge clk); guard++; end
    check("ready_before_issue", o_instr_ready, 1);
    @(negedge clk);
    i_instr_valid = 1'b1;
    i_instr_data  = ins;
    @(posedge clk); #1;
    i_instr_valid = 1'b0;
    i_instr_data  = $urandom;
    cycles = 0; busyCnt = 0;
    while (!o_instr_ready && cycles < maxWait) begin
      @(posedge clk); #1;
      cycles++;
      if (o_busy) busyCnt++;
    end
  endtask

  task automatic checkOutput(input string step);
    check({step, ".pc"},     o_pc,          mPc);
    check({step, ".mu"},     o_mu_cost,     mMu);
    check({step, ".status"}, o_status,      mStatus);
    check({step, ".err"},    o_error_code,  mErr);
    check({step, ".busy"},   o_busy,        0);
    check({step, ".halted"}, o_halted,      mHalted);
    check({step, ".ready"},  o_instr_ready, !mHalted);
  endtask

  task automatic runStep(input logic [31:0] ins, input string step);
    int expLat, expBusy, lat, bc, maxWait;
    modelExec(ins, expLat, expBusy);
    maxWait = (expLat < 0) ? 5 : expLat + 20;
    applyStimulus(ins, maxWait, lat, bc);
    check({step, ".latency"}, lat, (expLat < 0) ? maxWait : expLat);
    check({step, ".busyCycles"}, bc, expBusy);
    checkOutput(step);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    i_instr_valid = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    #1 checkOutput("reset");
    @(negedge clk) rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [7:0] op, a, b, cost;
    longint muBefore;
    for (int i = 0; i < NM; i++) for (int j = 0; j < RS; j++) begin
      mWr[i][j] = 0; mReg[i][j] = '0;
    end

    doReset();

    runStep(32'h01050003, "pnew1");
    check("pnew1.statusConst", o_status, 32'h0101);
    runStep(32'h01070002, "pnew2");
    check("pnew2.statusConst", o_status, 32'h0201);
    check("pnew2.muConst", o_mu_cost, 5);
    check("pnew2.pcConst", o_pc, 8);

    runStep(32'h01090001, "pnew3");
    runStep(32'h010A0004, "pnewFull");
    check("pnewFull.errConst", o_error_code, 2);
    check("pnewFull.muConst", o_mu_cost, 6);
    runStep(32'h03010200, "pmerge12");
    runStep(32'h010B0000, "pnewReuse");
    check("pnewReuse.statusConst", o_status, 32'h0201);

    runStep(32'h03010300, "pmerge13");
    for (int i = 1; i < RS; i++)
      runStep({8'h06, 8'h01, 8'(i), 8'($urandom) & 8'hFE}, "pwriteEven");
    muBefore = mMu;
    runStep(32'h02010102, "psplit");
    check("psplit.statusConst", o_status, 32'h00010302);
    check("psplit.muDelta", o_mu_cost, 8'(muBefore + 3));

    runStep(32'h03010100, "pmergeSame");
    check("pmergeSame.errConst", o_error_code, 3);
    runStep(32'h02070000, "psplitInvalid");
    check("psplitInvalid.errConst", o_error_code, 3);
    runStep(32'h42000000, "unknownOp");
    check("unknownOp.errConst", o_error_code, 1);

    for (int i = 0; i < RS; i++)
      runStep({8'h06, 8'h00, 8'(i), 8'($urandom)}, "fillRoot");
    for (int s = 0; s < 40; s++) begin
      a = 8'($urandom_range(0, 5));
      b = 8'($urandom_range(0, 11));
      cost = 8'($urandom);
      case ($urandom_range(0, 6))
        0: op = 8'h01;
        1: op = 8'h03;
        2: op = 8'h04;
        3: op = 8'h05;
        4: op = 8'h06;
        5: op = 8'h02;
        default: op = 8'h42 + 8'($urandom_range(0, 8));
      endcase
      if (op == 8'h02 && !allWritten(a)) op = 8'h06;
      runStep({op, a, b, cost}, "random");
    end

    doReset();
    for (int i = 0; i < RS; i++)
      runStep({8'h06, 8'h00, 8'(i), 8'($urandom)}, "fillRoot2");
    @(negedge clk);
    i_instr_valid = 1'b1;
    i_instr_data  = 32'h02000005;
    @(posedge clk); #1;
    i_instr_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("midsplit.busy", o_busy, 1);
    rst_n = 1'b0;
    modelReset();
    #1 checkOutput("midsplitReset");
    @(negedge clk) rst_n = 1'b1;
    runStep(32'h01110000, "pnewAfterAbort");
    check("pnewAfterAbort.statusConst", o_status, 32'h0101);

    for (int i = 0; i < 3; i++) runStep(32'h04000060, "lassertSat");
`ifdef MU_SATURATE_EN
    check("sat.muConst", o_mu_cost, 8'hFF);
    check("sat.errConst", o_error_code, 4);
`else
    check("wrap.muConst", o_mu_cost, 8'h20);
`endif

    runStep(32'hFF000007, "halt");
    check("halt.haltedConst", o_halted, 1);
    @(negedge clk);
    i_instr_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      i_instr_data = $urandom;
      @(negedge clk);
      check("halt.readyLow", o_instr_ready, 0);
    end
    i_instr_valid = 1'b0;
    check("halt.pcFrozen", o_pc, mPc);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
